// File: rtl/perf_pkg.sv
// Shared constants and types for the performance monitor: control FSM states,
// readout index width and counter overflow modes.
package perf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HALT
  } perf_state_e;

  localparam int unsigned IDX_W = 5;

  localparam int unsigned SAT_WRAP = 0;
  localparam int unsigned SAT_HOLD = 1;

endpackage

// File: rtl/perf_counter.sv
// Single event/cycle counter with synchronous clear and selectable
// wrap-around or saturate-at-all-ones overflow behaviour.
module perf_counter
  import perf_pkg::*;
#(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned SAT   = SAT_WRAP
) (
  input  logic             clk,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (SAT == SAT_HOLD && cnt_q == '1) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/perf_monitor.sv
// Cycle and per-channel event counters with an IDLE/RUN/HALT run controller
// and a snapshot bank streamed out over a valid/ready readout port.
module perf_monitor
  import perf_pkg::*;
#(
  parameter int unsigned NUM_EVT     = 2,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned SAT         = SAT_WRAP,
  parameter int unsigned CYCLE_LIMIT = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               clear_i,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic               snap_i,
  output logic               rd_valid_o,
  input  logic               rd_ready_i,
  output logic [IDX_W-1:0]   rd_idx_o,
  output logic [CNT_W-1:0]   rd_data_o,
  output logic               halt_o,
  output logic               busy_o
);

  localparam int unsigned       NUM_W    = NUM_EVT + 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_EVT);
  localparam logic [CNT_W-1:0]  LIMIT_M1 = CNT_W'(CYCLE_LIMIT - 1);

  perf_state_e      state_q, state_d;
  logic             busy_q, busy_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] shadow_q [NUM_W];
  logic [CNT_W-1:0] shadow_d [NUM_W];
  logic [CNT_W-1:0] cnt      [NUM_W];
  logic             counting;
  logic             cnt_clr;

  assign counting = (state_q == ST_RUN);
  assign cnt_clr  = rst | clear_i;

  // Slot 0 is the cycle counter, slot k+1 is event channel k.
  perf_counter #(.CNT_W(CNT_W), .SAT(SAT)) u_cyc_cnt (
    .clk   (clk),
    .en    (counting),
    .clr   (cnt_clr),
    .cnt_o (cnt[0])
  );

  for (genvar k = 0; k < NUM_EVT; k++) begin : g_evt
    perf_counter #(.CNT_W(CNT_W), .SAT(SAT)) u_evt_cnt (
      .clk   (clk),
      .en    (counting & evt_i[k]),
      .clr   (cnt_clr),
      .cnt_o (cnt[k+1])
    );
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (CYCLE_LIMIT != 0 && cnt[0] == LIMIT_M1) state_d = ST_HALT;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
    if (clear_i) state_d = ST_IDLE;
  end

  always_comb begin
    shadow_d = shadow_q;
    busy_d   = busy_q;
    idx_d    = idx_q;
    if (snap_i && !busy_q) begin
      shadow_d = cnt;
      busy_d   = 1'b1;
      idx_d    = '0;
    end else if (busy_q && rd_ready_i) begin
      if (idx_q == LAST_IDX) begin
        busy_d = 1'b0;
        idx_d  = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
    if (clear_i) begin
      busy_d = 1'b0;
      idx_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      idx_q   <= '0;
      for (int unsigned i = 0; i < NUM_W; i++) shadow_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int unsigned i = 0; i < NUM_W; i++) begin
      if (idx_q == IDX_W'(i)) rd_data_o = shadow_q[i];
    end
  end

  assign rd_valid_o = busy_q;
  assign busy_o     = busy_q;
  assign rd_idx_o   = idx_q;
  assign halt_o     = (state_q == ST_HALT);

endmodule

// File: tb/tb_perf_monitor.sv
// Directed self-checking bench for perf_monitor: default run-to-limit, wrap and
// saturate modes, snapshot stall/readout, clear and reset priority.
module tb_perf_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic [1:0]  evt = 2'b00;
  logic        snap = 1'b0;
  logic        ready = 1'b0;
  logic        valid, halt, busy;
  logic [4:0]  idx;
  logic [31:0] data;

  logic        w_start = 1'b0;
  logic        w_clear = 1'b0;
  logic [1:0]  w_evt = 2'b00;
  logic        w_snap = 1'b0;
  logic        w_ready = 1'b0;
  logic        wv, wh, wb, sv, sh, sb;
  logic [4:0]  widx, sidx;
  logic [7:0]  wdata, sdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  perf_monitor dut (
    .clk(clk), .rst(rst), .start(start), .clear_i(clear), .evt_i(evt),
    .snap_i(snap), .rd_valid_o(valid), .rd_ready_i(ready), .rd_idx_o(idx),
    .rd_data_o(data), .halt_o(halt), .busy_o(busy)
  );

  perf_monitor #(.NUM_EVT(2), .CNT_W(8), .SAT(0), .CYCLE_LIMIT(0)) dut_w (
    .clk(clk), .rst(rst), .start(w_start), .clear_i(w_clear), .evt_i(w_evt),
    .snap_i(w_snap), .rd_valid_o(wv), .rd_ready_i(w_ready), .rd_idx_o(widx),
    .rd_data_o(wdata), .halt_o(wh), .busy_o(wb)
  );

  perf_monitor #(.NUM_EVT(2), .CNT_W(8), .SAT(1), .CYCLE_LIMIT(0)) dut_s (
    .clk(clk), .rst(rst), .start(w_start), .clear_i(w_clear), .evt_i(w_evt),
    .snap_i(w_snap), .rd_valid_o(sv), .rd_ready_i(w_ready), .rd_idx_o(sidx),
    .rd_data_o(sdata), .halt_o(sh), .busy_o(sb)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({valid, halt, busy, idx, data} !== 40'd0) begin
      bad++;
      $display("FAIL reset_outputs got v=%b h=%b b=%b idx=%0d data=%0d exp all 0",
               valid, halt, busy, idx, data);
    end
    rst = 1'b0;
  endtask

  task automatic test_run_to_halt();
    logic [31:0] exp [3];
    exp = '{32'd30, 32'd30, 32'd0};
    start = 1'b1;
    evt   = 2'b01;
    tick();
    start = 1'b0;
    repeat (29) tick();
    total++;
    if (halt !== 1'b0) begin
      bad++;
      $display("FAIL halt_early got=%b exp=0", halt);
    end
    tick();
    total++;
    if (halt !== 1'b1) begin
      bad++;
      $display("FAIL halt_at_limit got=%b exp=1", halt);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (halt !== 1'b1) begin
      bad++;
      $display("FAIL halt_ignores_start got=%b exp=1", halt);
    end
    snap  = 1'b1;
    ready = 1'b1;
    tick();
    snap = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (valid !== 1'b1 || idx !== 5'(i) || data !== exp[i]) begin
        bad++;
        $display("FAIL halt_word%0d got v=%b idx=%0d data=%0d exp v=1 idx=%0d data=%0d",
                 i, valid, idx, data, i, exp[i]);
      end
      tick();
    end
    total++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL halt_stream_end got v=%b b=%b exp 0 0", valid, busy);
    end
  endtask

  task automatic test_rst_in_halt();
    logic [31:0] exp [3];
    exp = '{32'd5, 32'd5, 32'd0};
    ready = 1'b0;
    snap  = 1'b1;
    tick();
    snap = 1'b0;
    total++;
    if (busy !== 1'b1 || halt !== 1'b1) begin
      bad++;
      $display("FAIL pre_rst_state got b=%b h=%b exp 1 1", busy, halt);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({valid, halt, busy, idx, data} !== 40'd0) begin
      bad++;
      $display("FAIL rst_in_halt got v=%b h=%b b=%b idx=%0d data=%0d exp all 0",
               valid, halt, busy, idx, data);
    end
    start = 1'b1;
    evt   = 2'b01;
    tick();
    start = 1'b0;
    repeat (5) tick();
    snap = 1'b1;
    tick();
    snap  = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (valid !== 1'b1 || idx !== 5'(i) || data !== exp[i]) begin
        bad++;
        $display("FAIL restart_word%0d got v=%b idx=%0d data=%0d exp v=1 idx=%0d data=%0d",
                 i, valid, idx, data, i, exp[i]);
      end
      tick();
    end
  endtask

  task automatic test_snapshot_stall();
    logic [31:0] exp [3];
    exp = '{32'd10, 32'd0, 32'd10};
    ready = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b1;
    evt   = 2'b10;
    tick();
    start = 1'b0;
    repeat (10) tick();
    snap = 1'b1;
    tick();
    snap = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (valid !== 1'b1 || idx !== 5'd0 || data !== 32'd10) begin
        bad++;
        $display("FAIL stall%0d got v=%b idx=%0d data=%0d exp v=1 idx=0 data=10",
                 i, valid, idx, data);
      end
      if (i == 1) snap = 1'b1;
      tick();
      snap = 1'b0;
    end
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (valid !== 1'b1 || idx !== 5'(i) || data !== exp[i]) begin
        bad++;
        $display("FAIL snap_word%0d got v=%b idx=%0d data=%0d exp v=1 idx=%0d data=%0d",
                 i, valid, idx, data, i, exp[i]);
      end
      tick();
    end
    ready = 1'b0;
    total++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      bad++;
      $display("FAIL snap_stream_end got b=%b v=%b exp 0 0", busy, valid);
    end
    snap = 1'b1;
    tick();
    snap = 1'b0;
    total++;
    if (valid !== 1'b1 || idx !== 5'd0 || data !== 32'd17) begin
      bad++;
      $display("FAIL live_advance got v=%b idx=%0d data=%0d exp v=1 idx=0 data=17",
               valid, idx, data);
    end
  endtask

  task automatic test_clear_midstream();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    total++;
    if (idx !== 5'd1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL pre_clear_idx got idx=%0d b=%b exp idx=1 b=1", idx, busy);
    end
    clear = 1'b1;
    evt   = 2'b11;
    snap  = 1'b1;
    start = 1'b1;
    tick();
    clear = 1'b0;
    snap  = 1'b0;
    start = 1'b0;
    total++;
    if (valid !== 1'b0 || busy !== 1'b0 || halt !== 1'b0 || idx !== 5'd0) begin
      bad++;
      $display("FAIL clear_outputs got v=%b b=%b h=%b idx=%0d exp 0 0 0 0",
               valid, busy, halt, idx);
    end
    repeat (2) tick();
    snap = 1'b1;
    tick();
    snap  = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (valid !== 1'b1 || idx !== 5'(i) || data !== 32'd0) begin
        bad++;
        $display("FAIL clear_word%0d got v=%b idx=%0d data=%0d exp v=1 idx=%0d data=0",
                 i, valid, idx, data, i);
      end
      tick();
    end
    ready = 1'b0;
  endtask

  task automatic test_wrap_saturate();
    logic [7:0] exp_w [3];
    logic [7:0] exp_s [3];
    exp_w = '{8'd4, 8'd4, 8'd0};
    exp_s = '{8'd255, 8'd255, 8'd0};
    w_start = 1'b1;
    w_evt   = 2'b01;
    tick();
    w_start = 1'b0;
    repeat (260) tick();
    w_snap = 1'b1;
    tick();
    w_snap  = 1'b0;
    w_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (wv !== 1'b1 || widx !== 5'(i) || wdata !== exp_w[i]) begin
        bad++;
        $display("FAIL wrap_word%0d got v=%b idx=%0d data=%0d exp v=1 idx=%0d data=%0d",
                 i, wv, widx, wdata, i, exp_w[i]);
      end
      total++;
      if (sv !== 1'b1 || sidx !== 5'(i) || sdata !== exp_s[i]) begin
        bad++;
        $display("FAIL sat_word%0d got v=%b idx=%0d data=%0d exp v=1 idx=%0d data=%0d",
                 i, sv, sidx, sdata, i, exp_s[i]);
      end
      tick();
    end
    w_ready = 1'b0;
    total++;
    if (wh !== 1'b0 || sh !== 1'b0) begin
      bad++;
      $display("FAIL nolimit_halt got w=%b s=%b exp 0 0", wh, sh);
    end
  endtask

  initial begin
    test_reset();
    test_run_to_halt();
    test_rst_in_halt();
    test_snapshot_stall();
    test_clear_midstream();
    test_wrap_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
